// File: rtl/harmonica_rf_pkg.sv
// Shared sizing and FSM encoding for the operand-fetch / register-file slice.
// Latency: n/a. Backpressure: n/a.
package harmonica_rf_pkg;
  localparam int NUM_LANES  = 8;
  localparam int NUM_WARPS  = 8;
  localparam int NUM_REGS   = 16;
  localparam int DATA_W     = 32;
  localparam int LANE_BUS_W = NUM_LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/rf_port_arbiter.sv
// Arbitrates the shared register-file warp selector between writeback and operand read.
// Latency: combinational grant. Backpressure: wb_ready drops after STARVE_MAX stalled reads.
module rf_port_arbiter
  import harmonica_rf_pkg::*;
#(
  parameter int LANES      = NUM_LANES,
  parameter int BUS_W      = LANE_BUS_W,
  parameter int WARP_W     = $clog2(NUM_WARPS),
  parameter int REG_W      = $clog2(NUM_REGS),
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_read,
  input  logic [WARP_W-1:0] rd_warp,
  input  logic              wb_valid,
  input  logic [WARP_W-1:0] wb_warp,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [LANES-1:0]  wb_mask,
  input  logic [BUS_W-1:0]  wb_data,
  output logic              wb_ready,
  output logic              wb_grant,
  output logic              read_go,
  output logic [LANES-1:0]  rf_write_en,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [BUS_W-1:0]  rf_wdata,
  output logic [WARP_W-1:0] rf_warp_selector
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Counts READ cycles lost to writebacks; a successful read restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_read) begin
      if (wb_grant) stall_cnt <= stall_cnt + CNT_W'(1);
      else          stall_cnt <= '0;
    end
  end

  assign wb_ready = rst_n && (!in_read || (int'(stall_cnt) < STARVE_MAX));
  assign wb_grant = wb_valid && wb_ready;
  assign read_go  = rst_n && in_read && !wb_grant;

  always_comb begin
    rf_write_en      = '0;
    rf_waddr         = '0;
    rf_wdata         = '0;
    rf_warp_selector = '0;
    if (wb_grant) begin
      rf_write_en      = wb_mask;
      rf_waddr         = wb_addr;
      rf_wdata         = wb_data;
      rf_warp_selector = wb_warp;
    end else if (read_go) begin
      rf_warp_selector = rd_warp;
    end
  end
endmodule

// File: rtl/operand_fetch_ctrl.sv
// Fetches two source operands per issued warp instruction and holds them for the consumer.
// Latency: operands valid 2 cycles after issue acceptance when no writeback contends. Backpressure: one instruction in flight, iss_ready only in IDLE.
module operand_fetch_ctrl #(
  parameter  int NUM_LANES  = harmonica_rf_pkg::NUM_LANES,
  parameter  int NUM_WARPS  = harmonica_rf_pkg::NUM_WARPS,
  parameter  int NUM_REGS   = harmonica_rf_pkg::NUM_REGS,
  parameter  int DATA_W     = harmonica_rf_pkg::DATA_W,
  parameter  int STARVE_MAX = 3,
  localparam int WARP_W     = $clog2(NUM_WARPS),
  localparam int REG_W      = $clog2(NUM_REGS),
  localparam int BUS_W      = NUM_LANES * DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [WARP_W-1:0]    iss_warp,
  input  logic [REG_W-1:0]     iss_rs1,
  input  logic [REG_W-1:0]     iss_rs2,
  input  logic                 iss_use_rs2,
  input  logic [NUM_LANES-1:0] iss_mask,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [WARP_W-1:0]    wb_warp,
  input  logic [REG_W-1:0]     wb_addr,
  input  logic [NUM_LANES-1:0] wb_mask,
  input  logic [BUS_W-1:0]     wb_data,
  output logic [NUM_LANES-1:0] rf_read_en_0,
  output logic [NUM_LANES-1:0] rf_read_en_1,
  output logic [REG_W-1:0]     rf_raddr_0,
  output logic [REG_W-1:0]     rf_raddr_1,
  output logic [NUM_LANES-1:0] rf_write_en,
  output logic [REG_W-1:0]     rf_waddr,
  output logic [BUS_W-1:0]     rf_wdata,
  output logic [WARP_W-1:0]    rf_warp_selector,
  input  logic [BUS_W-1:0]     rf_rdata_0,
  input  logic [BUS_W-1:0]     rf_rdata_1,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [WARP_W-1:0]    op_warp,
  output logic [NUM_LANES-1:0] op_mask,
  output logic [BUS_W-1:0]     op_a,
  output logic [BUS_W-1:0]     op_b
);
  import harmonica_rf_pkg::*;

  fetch_state_t         state, state_nxt;
  logic [WARP_W-1:0]    lat_warp;
  logic [REG_W-1:0]     lat_rs1, lat_rs2;
  logic                 lat_use_rs2;
  logic [NUM_LANES-1:0] lat_mask;
  logic                 read_go, wb_grant, fwd_a, fwd_b;
  logic [BUS_W-1:0]     rd_lanes, wb_lanes;

  rf_port_arbiter #(
    .LANES(NUM_LANES), .BUS_W(BUS_W), .WARP_W(WARP_W), .REG_W(REG_W), .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk(clk), .rst_n(rst_n), .in_read(state == ST_READ), .rd_warp(lat_warp),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
    .wb_ready(wb_ready), .wb_grant(wb_grant), .read_go(read_go),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_warp_selector(rf_warp_selector)
  );

  always_comb begin
    rd_lanes = '0;
    wb_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_lanes[i*DATA_W +: DATA_W] = {DATA_W{lat_mask[i]}};
      wb_lanes[i*DATA_W +: DATA_W] = {DATA_W{wb_mask[i]}};
    end
  end

  // Held operands track writebacks to their own warp/register so they never go stale.
  assign fwd_a = wb_grant && (state == ST_VALID) && (wb_warp == lat_warp) && (wb_addr == lat_rs1);
  assign fwd_b = wb_grant && (state == ST_VALID) && (wb_warp == lat_warp) && lat_use_rs2
                 && (wb_addr == lat_rs2);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iss_valid && iss_ready) state_nxt = ST_READ;
      ST_READ:  if (read_go) state_nxt = ST_VALID;
      ST_VALID: if (op_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    iss_ready    = 1'b0;
    op_valid     = 1'b0;
    rf_read_en_0 = '0;
    rf_read_en_1 = '0;
    rf_raddr_0   = '0;
    rf_raddr_1   = '0;
    case (state)
      ST_IDLE:  iss_ready = rst_n;
      ST_READ: begin
        if (read_go) begin
          rf_read_en_0 = lat_mask;
          rf_raddr_0   = lat_rs1;
          rf_read_en_1 = lat_use_rs2 ? lat_mask : '0;
          rf_raddr_1   = lat_rs2;
        end
      end
      ST_VALID: op_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_warp    <= '0;
      lat_rs1     <= '0;
      lat_rs2     <= '0;
      lat_use_rs2 <= 1'b0;
      lat_mask    <= '0;
      op_a        <= '0;
      op_b        <= '0;
    end else begin
      if (iss_valid && iss_ready) begin
        lat_warp    <= iss_warp;
        lat_rs1     <= iss_rs1;
        lat_rs2     <= iss_rs2;
        lat_use_rs2 <= iss_use_rs2;
        lat_mask    <= iss_mask;
      end
      if (read_go) begin
        op_a <= rf_rdata_0 & rd_lanes;
        op_b <= lat_use_rs2 ? (rf_rdata_1 & rd_lanes) : '0;
      end else begin
        if (fwd_a) op_a <= (op_a & ~wb_lanes) | (wb_data & wb_lanes);
        if (fwd_b) op_b <= (op_b & ~wb_lanes) | (wb_data & wb_lanes);
      end
    end
  end

  assign op_warp = lat_warp;
  assign op_mask = lat_mask;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl with a behavioural register file behind the rf_* ports.
module tb_operand_fetch_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         iss_valid, iss_ready, iss_use_rs2;
  logic [2:0]   iss_warp;
  logic [3:0]   iss_rs1, iss_rs2;
  logic [7:0]   iss_mask;
  logic         wb_valid, wb_ready;
  logic [2:0]   wb_warp;
  logic [3:0]   wb_addr;
  logic [7:0]   wb_mask;
  logic [255:0] wb_data;
  logic [7:0]   rf_read_en_0, rf_read_en_1, rf_write_en;
  logic [3:0]   rf_raddr_0, rf_raddr_1, rf_waddr;
  logic [255:0] rf_wdata, rf_rdata_0, rf_rdata_1;
  logic [2:0]   rf_warp_selector;
  logic         op_valid, op_ready;
  logic [2:0]   op_warp;
  logic [7:0]   op_mask;
  logic [255:0] op_a, op_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [8][16][8];

  operand_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_use_rs2(iss_use_rs2), .iss_mask(iss_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_addr(wb_addr),
    .wb_mask(wb_mask), .wb_data(wb_data),
    .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1), .rf_raddr_0(rf_raddr_0),
    .rf_raddr_1(rf_raddr_1), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_warp_selector(rf_warp_selector),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
    .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp), .op_mask(op_mask),
    .op_a(op_a), .op_b(op_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int w, input int r, input int l);
    return {8'hA0 + 8'(w), 8'h50 + 8'(r), 8'h10 + 8'(l), 8'h3C};
  endfunction

  function automatic logic [255:0] exp_vec(input int w, input int r, input logic [7:0] m);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (m[i]) v[i*32 +: 32] = pat(w, r, i);
    return v;
  endfunction

  // Register file model: reads return every lane regardless of enable.
  initial begin
    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 16; r++)
        for (int l = 0; l < 8; l++) mem[w][r][l] = pat(w, r, l);
    forever begin
      @(posedge clk);
      for (int l = 0; l < 8; l++)
        if (rf_write_en[l]) mem[rf_warp_selector][rf_waddr][l] = rf_wdata[l*32 +: 32];
    end
  end

  always_comb begin
    rf_rdata_0 = '0;
    rf_rdata_1 = '0;
    for (int l = 0; l < 8; l++) begin
      rf_rdata_0[l*32 +: 32] = mem[rf_warp_selector][rf_raddr_0][l];
      rf_rdata_1[l*32 +: 32] = mem[rf_warp_selector][rf_raddr_1][l];
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] warp;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       use_rs2;
    logic [7:0] mask;
    logic       wb_hold;
    logic [7:0] exp_en1;
    int         exp_lat;
  } vec_t;

  vec_t vecs [5];

  localparam logic [255:0] WB_FILL = {8{32'h5A5A0000}};

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    iss_valid = 1'b1; iss_warp = v.warp; iss_rs1 = v.rs1; iss_rs2 = v.rs2;
    iss_use_rs2 = v.use_rs2; iss_mask = v.mask;
    #1 chk("iss_ready_idle", iss_ready, 1'b1);
    @(negedge clk);
    iss_valid = 1'b0;
    wb_valid = v.wb_hold; wb_warp = 3'd7; wb_addr = 4'd15; wb_mask = 8'hFF; wb_data = WB_FILL;
    for (int c = 0; c < v.exp_lat; c++) begin
      #1;
      chk("op_valid_read", op_valid, 1'b0);
      if (v.wb_hold) chk("wb_ready_read", wb_ready, (c < 3) ? 1'b1 : 1'b0);
      if (c == v.exp_lat - 1) begin
        chk("rd_en0", rf_read_en_0, v.mask);
        chk("rd_en1", rf_read_en_1, v.exp_en1);
        chk("raddr0", rf_raddr_0, v.rs1);
        chk("raddr1", rf_raddr_1, v.rs2);
        chk("rd_warp_sel", rf_warp_selector, v.warp);
        chk("wr_en_read", rf_write_en, 8'h00);
      end else begin
        chk("rd_en0_stall", rf_read_en_0, 8'h00);
        chk("wr_en_stall", rf_write_en, 8'hFF);
        chk("wr_warp_sel", rf_warp_selector, 3'd7);
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    #1;
    chk("op_valid", op_valid, 1'b1);
    chk("op_a", op_a, exp_vec(v.warp, v.rs1, v.mask));
    chk("op_b", op_b, v.use_rs2 ? exp_vec(v.warp, v.rs2, v.mask) : 256'h0);
    chk("op_warp", op_warp, v.warp);
    chk("op_mask", op_mask, v.mask);
    chk("wb_ready_valid", wb_ready, 1'b1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    #1;
    chk("op_valid_drop", op_valid, 1'b0);
    chk("iss_ready_back", iss_ready, 1'b1);
  endtask

  task automatic issue_to_valid(input logic [2:0] w, input logic [3:0] a, input logic [3:0] b,
                                input logic u, input logic [7:0] m);
    @(negedge clk);
    iss_valid = 1'b1; iss_warp = w; iss_rs1 = a; iss_rs2 = b; iss_use_rs2 = u; iss_mask = m;
    @(negedge clk);
    iss_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  logic [255:0] ea, eb;

  initial begin
    vecs[0] = '{3'd2, 4'd5, 4'd9,  1'b1, 8'hFF, 1'b0, 8'hFF, 1};
    vecs[1] = '{3'd1, 4'd3, 4'd4,  1'b0, 8'h0F, 1'b0, 8'h00, 1};
    vecs[2] = '{3'd4, 4'd7, 4'd7,  1'b1, 8'hA5, 1'b1, 8'hA5, 4};
    vecs[3] = '{3'd0, 4'd0, 4'd14, 1'b1, 8'h80, 1'b0, 8'h80, 1};
    vecs[4] = '{3'd6, 4'd12, 4'd1, 1'b0, 8'h3C, 1'b1, 8'h00, 4};

    rst_n = 1'b0; iss_valid = 1'b0; iss_warp = '0; iss_rs1 = '0; iss_rs2 = '0;
    iss_use_rs2 = 1'b0; iss_mask = '0; op_ready = 1'b0;
    wb_valid = 1'b1; wb_warp = 3'd7; wb_addr = 4'd15; wb_mask = 8'hFF; wb_data = WB_FILL;
    @(negedge clk); #1;
    chk("rst_iss_ready", iss_ready, 1'b0);
    chk("rst_wb_ready", wb_ready, 1'b0);
    chk("rst_wr_en", rf_write_en, 8'h00);
    chk("rst_rd_en", rf_read_en_0, 8'h00);
    @(negedge clk); #1;
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_op_a", op_a, 256'h0);
    chk("rst_op_b", op_b, 256'h0);
    chk("rst_op_warp", op_warp, 3'd0);
    chk("rst_op_mask", op_mask, 8'h00);
    rst_n = 1'b1; wb_valid = 1'b0;
    #1;
    chk("idle_warp_sel", rf_warp_selector, 3'd0);
    chk("idle_iss_ready", iss_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Forwarding into held operands.
    issue_to_valid(3'd2, 4'd5, 4'd9, 1'b1, 8'hFF);
    chk("fwd_op_valid", op_valid, 1'b1);
    wb_valid = 1'b1; wb_warp = 3'd2; wb_addr = 4'd5; wb_mask = 8'h01;
    wb_data = {{7{32'h11111111}}, 32'hDEADBEEF};
    #1 chk("fwd_wr_en", rf_write_en, 8'h01);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    ea = exp_vec(2, 5, 8'hFF);
    ea[31:0] = 32'hDEADBEEF;
    eb = exp_vec(2, 9, 8'hFF);
    chk("fwd_op_a", op_a, ea);
    chk("fwd_op_b_same", op_b, eb);
    chk("fwd_still_valid", op_valid, 1'b1);
    wb_valid = 1'b1; wb_warp = 3'd3; wb_addr = 4'd5; wb_mask = 8'hFF; wb_data = WB_FILL;
    @(negedge clk);
    wb_valid = 1'b0;
    #1 chk("fwd_other_warp", op_a, ea);
    wb_valid = 1'b1; wb_warp = 3'd2; wb_addr = 4'd9; wb_mask = 8'h80;
    wb_data = {32'hCAFEF00D, {7{32'h22222222}}};
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    eb[255:224] = 32'hCAFEF00D;
    chk("fwd_op_b", op_b, eb);
    chk("fwd_op_a_kept", op_a, ea);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;

    // Reset while operands are held.
    issue_to_valid(3'd1, 4'd2, 4'd3, 1'b1, 8'hF0);
    chk("pre_rst_valid", op_valid, 1'b1);
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_warp = 3'd1; wb_addr = 4'd2; wb_mask = 8'hFF; wb_data = WB_FILL;
    #1;
    chk("mid_rst_wr_en", rf_write_en, 8'h00);
    chk("mid_rst_wb_ready", wb_ready, 1'b0);
    chk("mid_rst_iss_ready", iss_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; wb_valid = 1'b0;
    #1;
    chk("post_rst_op_valid", op_valid, 1'b0);
    chk("post_rst_op_a", op_a, 256'h0);
    chk("post_rst_op_mask", op_mask, 8'h00);
    @(negedge clk); #1;
    chk("post_rst_iss_ready", iss_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
